// File: rtl/bsg_yumi_to_ready_fifo.sv
// Two-entry FIFO that accepts from a yumi-style (valid/consume) producer
// and presents a registered valid/ready interface to the consumer.
//
// Ports:
//   clk_i    : clock, all state updates on the rising edge
//   reset_i  : synchronous active-high reset
//   v_i      : upstream valid; the producer holds v_i/data_i until yumi_o
//   data_i   : upstream payload, width_p bits
//   yumi_o   : upstream accept; data_i is consumed in a cycle with yumi_o=1
//   v_o      : downstream valid, driven from registers only
//   data_o   : downstream payload, meaningful only while v_o=1
//   ready_i  : downstream ready; a transfer happens on v_o & ready_i
module bsg_yumi_to_ready_fifo #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               yumi_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic [width_p-1:0] r_mem [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;

    logic               w_full;
    logic               w_enq;
    logic               w_deq;

    // Accept depends only on occupancy, never on ready_i, so a slot
    // freed by a dequeue becomes usable on the following cycle.
    assign w_full = (r_count == 2'd2);
    assign w_enq  = v_i & ~w_full & ~reset_i;
    assign w_deq  = v_o & ready_i;

    assign yumi_o = w_enq;
    assign v_o    = (r_count != 2'd0);
    assign data_o = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) begin
                r_wptr <= ~r_wptr;
            end
            if (w_deq) begin
                r_rptr <= ~r_rptr;
            end
            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= data_i;
        end
    end

endmodule

// File: tb/tb_bsg_yumi_to_ready_fifo.sv
// Directed and scoreboarded checks for bsg_yumi_to_ready_fifo.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_bsg_yumi_to_ready_fifo;

    logic        clk_i;
    logic        reset_i;
    logic        v_i;
    logic [15:0] data_i;
    logic        yumi_o;
    logic        v_o;
    logic [15:0] data_o;
    logic        ready_i;

    int vectors;
    int miscompares;

    bsg_yumi_to_ready_fifo #(.width_p(16)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .yumi_o  (yumi_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic drive(input logic rst, input logic v,
                         input logic [15:0] d, input logic r);
        @(negedge clk_i);
        reset_i = rst;
        v_i     = v;
        data_i  = d;
        ready_i = r;
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, 16'h5A5A, 1'b0);
        vectors++;
        if (yumi_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_yumi got %b want 0", yumi_o);
        end
        drive(1'b1, 1'b1, 16'h5A5A, 1'b1);
        vectors++;
        if (v_o !== 1'b0 || yumi_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_hold v_o=%b yumi=%b want 0 0",
                     v_o, yumi_o);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        vectors++;
        if (v_o !== 1'b0 || yumi_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after v_o=%b yumi=%b want 0 0",
                     v_o, yumi_o);
        end
    endtask

    task automatic test_single;
        drive(1'b0, 1'b1, 16'hA5A5, 1'b0);
        vectors++;
        if (yumi_o !== 1'b1 || v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_acc yumi=%b v_o=%b want 1 0",
                     yumi_o, v_o);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (v_o !== 1'b1 || data_o !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL single_out v_o=%b data=%h want 1 a5a5",
                     v_o, data_o);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        vectors++;
        if (v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drain v_o=%b want 0", v_o);
        end
    endtask

    task automatic test_fill_stall;
        logic [15:0] exp_d [3];
        exp_d[0] = 16'd1;
        exp_d[1] = 16'd2;
        exp_d[2] = 16'd3;
        drive(1'b0, 1'b1, 16'd1, 1'b0);
        vectors++;
        if (yumi_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_w1 yumi=%b want 1", yumi_o);
        end
        drive(1'b0, 1'b1, 16'd2, 1'b0);
        vectors++;
        if (yumi_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_w2 yumi=%b want 1", yumi_o);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 16'd3, 1'b0);
            vectors++;
            if (yumi_o !== 1'b0 || v_o !== 1'b1 ||
                data_o !== 16'd1) begin
                miscompares++;
                $display("FAIL fill_stall yumi=%b v_o=%b data=%h %s",
                         yumi_o, v_o, data_o, "want 0 1 0001");
            end
        end
        drive(1'b0, 1'b1, 16'd3, 1'b1);
        vectors++;
        if (yumi_o !== 1'b0 || data_o !== exp_d[0]) begin
            miscompares++;
            $display("FAIL fill_fullrdy yumi=%b data=%h want 0 0001",
                     yumi_o, data_o);
        end
        drive(1'b0, 1'b1, 16'd3, 1'b1);
        vectors++;
        if (yumi_o !== 1'b1 || data_o !== exp_d[1]) begin
            miscompares++;
            $display("FAIL fill_o2 yumi=%b data=%h want 1 0002",
                     yumi_o, data_o);
        end
        drive(1'b0, 1'b0, 16'd0, 1'b1);
        vectors++;
        if (v_o !== 1'b1 || data_o !== exp_d[2]) begin
            miscompares++;
            $display("FAIL fill_o3 v_o=%b data=%h want 1 0003",
                     v_o, data_o);
        end
        drive(1'b0, 1'b0, 16'd0, 1'b0);
        vectors++;
        if (v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_empty v_o=%b want 0", v_o);
        end
    endtask

    task automatic test_full_ready;
        drive(1'b0, 1'b1, 16'h0010, 1'b0);
        drive(1'b0, 1'b1, 16'h0011, 1'b0);
        drive(1'b0, 1'b1, 16'h0012, 1'b1);
        vectors++;
        if (yumi_o !== 1'b0 || v_o !== 1'b1 ||
            data_o !== 16'h0010) begin
            miscompares++;
            $display("FAIL fullrdy_cyc yumi=%b v_o=%b data=%h %s",
                     yumi_o, v_o, data_o, "want 0 1 0010");
        end
        drive(1'b0, 1'b1, 16'h0012, 1'b0);
        vectors++;
        if (yumi_o !== 1'b1 || data_o !== 16'h0011) begin
            miscompares++;
            $display("FAIL fullrdy_next yumi=%b data=%h want 1 0011",
                     yumi_o, data_o);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        vectors++;
        if (v_o !== 1'b1 || data_o !== 16'h0012) begin
            miscompares++;
            $display("FAIL fullrdy_o3 v_o=%b data=%h want 1 0012",
                     v_o, data_o);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fullrdy_empty v_o=%b want 0", v_o);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 16'(i), 1'b1);
            vectors++;
            if (yumi_o !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_yumi i=%0d got %b want 1",
                         i, yumi_o);
            end
            if (i == 0) begin
                vectors++;
                if (v_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_lat v_o=%b want 0", v_o);
                end
            end else begin
                vectors++;
                if (v_o !== 1'b1 || data_o !== 16'(i - 1)) begin
                    miscompares++;
                    $display("FAIL stream_out i=%0d v_o=%b %s %h %h",
                             i, v_o, "data/want", data_o,
                             16'(i - 1));
                end
            end
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        vectors++;
        if (v_o !== 1'b1 || data_o !== 16'd99) begin
            miscompares++;
            $display("FAIL stream_last v_o=%b data=%h want 1 0063",
                     v_o, data_o);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_empty v_o=%b want 0", v_o);
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b0, 1'b1, 16'h0055, 1'b0);
        drive(1'b0, 1'b1, 16'h0066, 1'b0);
        drive(1'b1, 1'b1, 16'h0077, 1'b0);
        vectors++;
        if (yumi_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_yumi got %b want 0", yumi_o);
        end
        drive(1'b0, 1'b1, 16'h0088, 1'b0);
        vectors++;
        if (v_o !== 1'b0 || yumi_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_after v_o=%b yumi=%b want 0 1",
                     v_o, yumi_o);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        vectors++;
        if (v_o !== 1'b1 || data_o !== 16'h0088) begin
            miscompares++;
            $display("FAIL midrst_first v_o=%b data=%h want 1 0088",
                     v_o, data_o);
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        vectors++;
        if (v_o !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_empty v_o=%b want 0", v_o);
        end
    endtask

    task automatic test_random;
        logic [15:0] q [$];
        logic        hold_v;
        logic [15:0] hold_d;
        logic        cur_v;
        logic [15:0] cur_d;
        logic        cur_r;
        logic        exp_yumi;
        logic        exp_v;
        logic        prev_stall;
        logic [15:0] prev_d;
        hold_v     = 1'b0;
        hold_d     = 16'h0;
        prev_stall = 1'b0;
        prev_d     = 16'h0;
        for (int c = 0; c < 10000; c++) begin
            if (hold_v) begin
                cur_v = 1'b1;
                cur_d = hold_d;
            end else begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = 16'($urandom);
            end
            cur_r = ($urandom_range(0, 2) != 0);
            drive(1'b0, cur_v, cur_d, cur_r);
            exp_yumi = cur_v && (q.size() != 2);
            exp_v    = (q.size() != 0);
            vectors++;
            if (yumi_o !== exp_yumi) begin
                miscompares++;
                $display("FAIL rand_yumi c=%0d got %b want %b",
                         c, yumi_o, exp_yumi);
            end
            vectors++;
            if (v_o !== exp_v) begin
                miscompares++;
                $display("FAIL rand_v c=%0d got %b want %b",
                         c, v_o, exp_v);
            end
            if (exp_v) begin
                vectors++;
                if (data_o !== q[0]) begin
                    miscompares++;
                    $display("FAIL rand_data c=%0d got %h want %h",
                             c, data_o, q[0]);
                end
            end
            if (prev_stall) begin
                vectors++;
                if (data_o !== prev_d) begin
                    miscompares++;
                    $display("FAIL rand_stable c=%0d got %h want %h",
                             c, data_o, prev_d);
                end
            end
            prev_stall = exp_v && !cur_r;
            prev_d     = exp_v ? q[0] : 16'h0;
            if (exp_v && cur_r) begin
                void'(q.pop_front());
            end
            if (exp_yumi) begin
                q.push_back(cur_d);
            end
            hold_v = cur_v && !exp_yumi;
            hold_d = cur_d;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_i     = 1'b1;
        v_i         = 1'b0;
        data_i      = 16'h0;
        ready_i     = 1'b0;
        test_reset();
        test_single();
        test_fill_stall();
        test_full_ready();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
